cpu_program_sequencer: RTL and testbench

Instruction issuer and result collector for the 8-bit accumulator CPU core. It drives the core's 8-bit instruction input and samples the core's 8-bit result output.
A host loads a short program (instruction words {operand[7:4], opcode[3:0]}) into an internal buffer. On start, the block issues the program to the core using the core's 2-cycle slot timing, then captures the final accumulator value.
It sits between the host/test logic and the CPU core inside the user design.

---
 rtl/cpu_program_sequencer.sv | 129 ++++++++++++
 tb/tb_cpu_program_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_sequencer.sv
// rtl/cpu_program_sequencer.sv - program buffer and 2-cycle slot issuer for the 8-bit accumulator core
module cpu_program_sequencer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  output logic [7:0]    instr_out,
  input  logic [7:0]    result_in,
  output logic [7:0]    result_out,
  output logic          result_valid,
  output logic          busy,
  output logic [AW:0]   prog_count
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SLOT_A = 3'd1,
    SLOT_B = 3'd2,
    DRAIN1 = 3'd3,
    DRAIN2 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] ptr;
  logic [AW:0] ptr_nxt;
  logic [AW:0] count_next;
  logic [7:0]  first_word;
  logic        is_idle;
  logic        accept;

  assign is_idle    = (state == IDLE);
  assign busy       = !is_idle;
  assign load_ready = is_idle && (prog_count < DEPTH_W);
  // clear wins over a same-cycle load, so the dropped word is never written
  assign accept     = ena && load_valid && load_ready && !clear;
  assign ptr_nxt    = ptr + 1'b1;
  // a word loaded in the same cycle as start at address 0 is not yet in the array
  assign first_word = (accept && prog_count == '0) ? load_data : mem[0];

  // Count after this cycle's clear/load, so start sees the updated program length
  always_comb begin
    count_next = prog_count;
    if (is_idle && clear)
      count_next = '0;
    else if (accept)
      count_next = prog_count + 1'b1;
  end

  // Program buffer storage; contents are not reset
  always_ff @(posedge clk) begin
    if (accept)
      mem[prog_count[AW-1:0]] <= load_data;
  end

  // Issue FSM with registered instruction and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      prog_count   <= '0;
      instr_out    <= 8'h00;
      result_out   <= 8'h00;
      result_valid <= 1'b0;
    end else if (ena) begin
      prog_count   <= count_next;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          instr_out <= 8'h00;
          if (start) begin
            ptr <= '0;
            if (count_next == '0) begin
              state <= DRAIN1;
            end else begin
              state     <= SLOT_A;
              instr_out <= first_word;
            end
          end
        end
        SLOT_A: begin
          // same operand, opcode cleared: the core executes the opcode latched in SLOT_A
          instr_out <= {instr_out[7:4], 4'h0};
          state     <= SLOT_B;
        end
        SLOT_B: begin
          ptr <= ptr_nxt;
          if (ptr_nxt == prog_count) begin
            state     <= DRAIN1;
            instr_out <= 8'h00;
          end else begin
            state     <= SLOT_A;
            instr_out <= mem[ptr_nxt[AW-1:0]];
          end
        end
        DRAIN1: begin
          instr_out <= 8'h00;
          state     <= DRAIN2;
        end
        DRAIN2: begin
          // the core result is settled two cycles after the last operand slot
          instr_out    <= 8'h00;
          result_out   <= result_in;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          instr_out <= 8'h00;
          state     <= IDLE;
        end
        default: begin
          instr_out <= 8'h00;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// tb/tb_cpu_program_sequencer.sv - directed self-checking bench for cpu_program_sequencer
module tb_cpu_program_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          clear;
  logic          start;
  logic [7:0]    instr_out;
  logic [7:0]    result_in;
  logic [7:0]    result_out;
  logic          result_valid;
  logic          busy;
  logic [AW:0]   prog_count;

  int errors = 0;
  int checks = 0;

  cpu_program_sequencer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .clear        (clear),
    .start        (start),
    .instr_out    (instr_out),
    .result_in    (result_in),
    .result_out   (result_out),
    .result_valid (result_valid),
    .busy         (busy),
    .prog_count   (prog_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accumulator core model: opcode latched when nonzero, executed with next operand
  // opcodes: 1 add, 2 sub, 3 load
  logic       core_rst_n;
  logic [7:0] acc;
  logic [3:0] op;
  assign result_in = acc;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      acc <= 8'h00;
      op  <= 4'h0;
    end else if (instr_out[3:0] != 4'h0) begin
      op <= instr_out[3:0];
    end else if (op != 4'h0) begin
      case (op)
        4'h1: acc <= acc + {4'h0, instr_out[7:4]};
        4'h2: acc <= acc - {4'h0, instr_out[7:4]};
        4'h3: acc <= {4'h0, instr_out[7:4]};
        default: acc <= acc;
      endcase
      op <= 4'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  // ticks until result_valid, bounded; returns cycles waited
  task automatic wait_rv(output int n);
    n = 0;
    while (!result_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic core_reset();
    core_rst_n = 1'b0;
    tick();
    core_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq [8];
    int n;
    int pulses;
    seq = '{8'h31, 8'h30, 8'h21, 8'h20, 8'h12, 8'h10, 8'h00, 8'h00};

    rst_n = 1'b0; core_rst_n = 1'b0; ena = 1'b1;
    load_valid = 1'b0; load_data = 8'h00; clear = 1'b0; start = 1'b0;
    tick(); tick();
    chk("rst_count", 16'(prog_count), 16'd0);
    chk("rst_instr", 16'(instr_out), 16'h00);
    chk("rst_result", 16'(result_out), 16'h00);
    chk("rst_rv", 16'(result_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ready", 16'(load_ready), 16'd1);
    rst_n = 1'b1; core_rst_n = 1'b1;
    tick();

    // basic three-instruction program
    load_word(8'h31); load_word(8'h21); load_word(8'h12);
    chk("load_count", 16'(prog_count), 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("run1_instr%0d", i), 16'(instr_out), 16'(seq[i]));
      chk($sformatf("run1_busy%0d", i), 16'(busy), 16'd1);
      chk($sformatf("run1_rv%0d", i), 16'(result_valid), 16'd0);
      tick();
    end
    chk("run1_rv", 16'(result_valid), 16'd1);
    chk("run1_result", 16'(result_out), 16'h04);
    chk("run1_done_busy", 16'(busy), 16'd1);
    tick();
    chk("run1_rv_pulse", 16'(result_valid), 16'd0);
    chk("run1_idle", 16'(busy), 16'd0);
    chk("run1_idle_instr", 16'(instr_out), 16'h00);

    // empty program: straight to drain, reports current core value
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_count", 16'(prog_count), 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_instr1", 16'(instr_out), 16'h00);
    chk("empty_busy", 16'(busy), 16'd1);
    tick();
    chk("empty_instr2", 16'(instr_out), 16'h00);
    chk("empty_rv_early", 16'(result_valid), 16'd0);
    tick();
    chk("empty_rv", 16'(result_valid), 16'd1);
    chk("empty_result", 16'(result_out), 16'h04);
    tick();

    // fill to DEPTH, overflow dropped, clear priority
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("fill_ready%0d", i), 16'(load_ready), 16'd1);
      load_word(8'(i + 1));
    end
    chk("full_count", 16'(prog_count), 16'(DEPTH));
    chk("full_ready", 16'(load_ready), 16'd0);
    load_word(8'hFF);
    chk("full_drop", 16'(prog_count), 16'(DEPTH));
    clear = 1'b1; tick(); clear = 1'b0;
    chk("full_clear", 16'(prog_count), 16'd0);
    chk("clear_ready", 16'(load_ready), 16'd1);
    clear = 1'b1; load_word(8'h55); clear = 1'b0;
    chk("clear_prio", 16'(prog_count), 16'd0);

    // ena freeze during SLOT_B of the first instruction
    load_word(8'h31); load_word(8'h21); load_word(8'h12);
    core_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("freeze_slotb", 16'(instr_out), 16'h30);
    ena = 1'b0;
    start = 1'b1; load_valid = 1'b1; load_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("freeze_instr%0d", i), 16'(instr_out), 16'h30);
      chk($sformatf("freeze_busy%0d", i), 16'(busy), 16'd1);
    end
    start = 1'b0; load_valid = 1'b0;
    ena = 1'b1;
    tick();
    chk("resume_instr", 16'(instr_out), 16'h21);
    wait_rv(n);
    chk("resume_latency", 16'(n), 16'd6);
    chk("resume_result", 16'(result_out), 16'h04);
    chk("resume_count", 16'(prog_count), 16'd3);
    tick();

    // start/load/clear while busy are ignored; buffer re-issued without reload
    core_reset();
    start = 1'b1; tick();
    load_valid = 1'b1; load_data = 8'h99; clear = 1'b1;
    chk("busy_ready", 16'(load_ready), 16'd0);
    tick();
    chk("busy_ready2", 16'(load_ready), 16'd0);
    chk("busy_instr", 16'(instr_out), 16'h30);
    tick();
    start = 1'b0; load_valid = 1'b0; clear = 1'b0;
    chk("busy_instr2", 16'(instr_out), 16'h21);
    chk("busy_count", 16'(prog_count), 16'd3);
    wait_rv(n);
    chk("busy_latency", 16'(n), 16'd6);
    chk("busy_result", 16'(result_out), 16'h04);
    tick();
    chk("busy_back_idle", 16'(busy), 16'd0);

    // async reset during SLOT_A of instruction 2
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre_rst_instr", 16'(instr_out), 16'h21);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_instr", 16'(instr_out), 16'h00);
    chk("arst_count", 16'(prog_count), 16'd0);
    chk("arst_ready", 16'(load_ready), 16'd1);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    chk("arst_no_rv", 16'(pulses), 16'd0);
    chk("arst_idle", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
